// File: rtl/mem_arbiter.sv
// mem_arbiter: shares the single external memory bus between the instruction-fetch
//   port and the data port. Data has fixed priority over fetch. A watchdog aborts
//   any access that waits TIMEOUT cycles without bus_ack.
// Latency: request sampled at t -> bus_req at t+1; ack at t+k -> ready at t+k+1;
//   next grant is sampled at t+k+2 (minimum three cycles per access).
// Backpressure: the requester holds req until its ready pulse; stalls are
//   combinational (req & ~ready) so the pipeline advances on the ready edge.
//
// Ports:
//   clk, reset            rising-edge clock, synchronous active-high reset
//   if_req/if_addr        fetch request (may drop early on a flush)
//   if_ready/if_rdata     one-cycle fetch completion, registered fetch data
//   d_req/d_we/d_be/      data request and command (must hold until d_ready)
//   d_addr/d_wdata
//   d_ready/d_rdata       one-cycle data completion, registered load data
//   bus_req/bus_we/...    registered bus command, held stable during the access
//   bus_ack/bus_rdata     slave completion strobe and read data
//   if_stall/mem_stall    combinational stall requests to the pipeline
//   bus_err/bus_err_src   one-cycle timeout pulse, source (0 fetch, 1 data)

module mem_arbiter #(
  parameter int TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        reset,

  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic        if_ready,
  output logic [31:0] if_rdata,

  input  logic        d_req,
  input  logic        d_we,
  input  logic [3:0]  d_be,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  output logic        d_ready,
  output logic [31:0] d_rdata,

  output logic        bus_req,
  output logic        bus_we,
  output logic [3:0]  bus_be,
  output logic [31:0] bus_addr,
  output logic [31:0] bus_wdata,
  input  logic        bus_ack,
  input  logic [31:0] bus_rdata,

  output logic        if_stall,
  output logic        mem_stall,
  output logic        bus_err,
  output logic        bus_err_src
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    DBUS  = 3'd1,
    IBUS  = 3'd2,
    DDONE = 3'd3,
    IDONE = 3'd4
  } state_t;

  // Last wait count value before the watchdog fires. The counter starts at 0 in
  // the first bus cycle, so firing at TIMEOUT-1 keeps bus_req high for exactly
  // TIMEOUT cycles.
  localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT - 1);

  state_t     state;
  logic [7:0] wait_cnt;
  logic       abandon;

  logic       wait_expired;
  logic       abandon_now;

  assign wait_expired = (wait_cnt == WAIT_LAST);

  // A fetch is abandoned if its requester was flushed in any bus cycle,
  // including the cycle the ack arrives in.
  assign abandon_now  = abandon | ~if_req;

  // Stalls follow the requests directly; they drop in the ready cycle so the
  // pipeline registers capture the result on that edge.
  assign if_stall  = ~reset & if_req & ~if_ready;
  assign mem_stall = ~reset & d_req  & ~d_ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      wait_cnt    <= 8'd0;
      abandon     <= 1'b0;
      bus_req     <= 1'b0;
      bus_we      <= 1'b0;
      bus_be      <= 4'h0;
      bus_addr    <= 32'h0;
      bus_wdata   <= 32'h0;
      if_ready    <= 1'b0;
      if_rdata    <= 32'h0;
      d_ready     <= 1'b0;
      d_rdata     <= 32'h0;
      bus_err     <= 1'b0;
      bus_err_src <= 1'b0;
    end else begin
      // Completion strobes are single-cycle pulses.
      if_ready    <= 1'b0;
      d_ready     <= 1'b0;
      bus_err     <= 1'b0;
      bus_err_src <= 1'b0;

      case (state)
        IDLE: begin
          wait_cnt <= 8'd0;
          abandon  <= 1'b0;
          // Data wins a same-cycle conflict; a pending data access already
          // freezes the fetch stage, so fetch cannot starve.
          if (d_req) begin
            bus_req   <= 1'b1;
            bus_we    <= d_we;
            bus_be    <= d_be;
            bus_addr  <= d_addr;
            bus_wdata <= d_wdata;
            state     <= DBUS;
          end else if (if_req) begin
            bus_req  <= 1'b1;
            bus_we   <= 1'b0;
            bus_be   <= 4'hF;
            bus_addr <= if_addr;
            state    <= IBUS;
          end
        end

        DBUS: begin
          if (bus_ack) begin
            bus_req <= 1'b0;
            d_rdata <= bus_rdata;
            d_ready <= 1'b1;
            state   <= DDONE;
          end else if (wait_expired) begin
            bus_req     <= 1'b0;
            d_rdata     <= 32'h0;
            d_ready     <= 1'b1;
            bus_err     <= 1'b1;
            bus_err_src <= 1'b1;
            state       <= DDONE;
          end else begin
            wait_cnt <= wait_cnt + 8'd1;
          end
        end

        IBUS: begin
          // The bus transaction cannot be aborted, so an abandoned fetch still
          // runs to completion; only its ready pulse is suppressed.
          abandon <= abandon_now;
          if (bus_ack) begin
            bus_req  <= 1'b0;
            if_rdata <= bus_rdata;
            if_ready <= ~abandon_now;
            state    <= IDONE;
          end else if (wait_expired) begin
            bus_req     <= 1'b0;
            if_rdata    <= 32'h0;
            if_ready    <= ~abandon_now;
            bus_err     <= 1'b1;
            bus_err_src <= 1'b0;
            state       <= IDONE;
          end else begin
            wait_cnt <= wait_cnt + 8'd1;
          end
        end

        // One dead cycle after every access: the requester's req is still high
        // here and must not be granted a second time.
        DDONE: begin
          abandon <= 1'b0;
          state   <= IDLE;
        end

        IDONE: begin
          abandon <= 1'b0;
          state   <= IDLE;
        end

        default: begin
          bus_req <= 1'b0;
          state   <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed cycle tables for the documented corner cases, then
//   randomized traffic checked against a transaction-level reference model.
// Latency/backpressure: the bench plays both requesters and the bus slave.

module tb_mem_arbiter;

  localparam int TO    = 4;
  localparam int NRAND = 3000;

  logic        clk = 1'b0;
  logic        reset;
  logic        if_req;
  logic [31:0] if_addr;
  logic        if_ready;
  logic [31:0] if_rdata;
  logic        d_req;
  logic        d_we;
  logic [3:0]  d_be;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic        d_ready;
  logic [31:0] d_rdata;
  logic        bus_req;
  logic        bus_we;
  logic [3:0]  bus_be;
  logic [31:0] bus_addr;
  logic [31:0] bus_wdata;
  logic        bus_ack;
  logic [31:0] bus_rdata;
  logic        if_stall;
  logic        mem_stall;
  logic        bus_err;
  logic        bus_err_src;

  int n_cmp = 0;
  int n_bad = 0;
  int where = 0;

  always #5 clk = ~clk;

  mem_arbiter #(.TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset),
    .if_req(if_req), .if_addr(if_addr), .if_ready(if_ready), .if_rdata(if_rdata),
    .d_req(d_req), .d_we(d_we), .d_be(d_be), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_ready(d_ready), .d_rdata(d_rdata),
    .bus_req(bus_req), .bus_we(bus_we), .bus_be(bus_be), .bus_addr(bus_addr),
    .bus_wdata(bus_wdata), .bus_ack(bus_ack), .bus_rdata(bus_rdata),
    .if_stall(if_stall), .mem_stall(mem_stall),
    .bus_err(bus_err), .bus_err_src(bus_err_src)
  );

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s @%0d: got %0h, expected %0h", name, where, act, exp);
    end
  endtask

  // One directed cycle: inputs driven for the cycle, outputs expected in it.
  // ic = {reset, if_req, d_req, d_we, bus_ack}
  // ec = {bus_req, bus_we, if_ready, d_ready, bus_err, bus_err_src, if_stall, mem_stall}
  typedef struct packed {
    logic [4:0]  ic;
    logic [3:0]  dbe;
    logic [31:0] iaddr;
    logic [31:0] daddr;
    logic [31:0] ardata;
    logic [7:0]  ec;
    logic [3:0]  e_bbe;
    logic [31:0] e_baddr;
    logic [31:0] e_irdata;
    logic [31:0] e_drdata;
  } vec_t;

  function automatic vec_t mk(input logic [4:0] ic, input logic [3:0] dbe,
                              input logic [31:0] iaddr, input logic [31:0] daddr,
                              input logic [31:0] ardata, input logic [7:0] ec,
                              input logic [3:0] e_bbe, input logic [31:0] e_baddr,
                              input logic [31:0] e_irdata, input logic [31:0] e_drdata);
    vec_t v;
    v.ic = ic; v.dbe = dbe; v.iaddr = iaddr; v.daddr = daddr; v.ardata = ardata;
    v.ec = ec; v.e_bbe = e_bbe; v.e_baddr = e_baddr;
    v.e_irdata = e_irdata; v.e_drdata = e_drdata;
    return v;
  endfunction

  vec_t vq[$];

  // Reference model state: one in-flight access record plus a pending report.
  logic        m_active;
  logic        m_src;        // 1 = data
  logic        m_aband;
  int          m_start;      // cycle the grant was sampled
  int          m_ack_due;
  int          m_arb_from;   // first cycle a new grant may be sampled
  logic        m_we;
  logic [3:0]  m_be;
  logic [31:0] m_addr;
  logic [31:0] m_wdata;
  logic [31:0] m_irdata;
  logic [31:0] m_drdata;
  int          rep_cyc;
  logic        rep_src;
  logic        rep_err;
  logic        rep_aband;

  initial begin
    logic        d_pend;
    logic        i_pend;
    logic        e_irdy;
    logic        e_drdy;
    logic        e_err;
    logic [31:0] dat;

    reset = 1'b1; if_req = 1'b0; if_addr = 32'h0; d_req = 1'b0; d_we = 1'b0;
    d_be = 4'h0; d_addr = 32'h0; d_wdata = 32'h0; bus_ack = 1'b0; bus_rdata = 32'h0;
    repeat (2) @(posedge clk);

    // reset state, single load with held request
    vq.push_back(mk(5'b11100, 4'hF, 32'h0, 32'h0,   32'h0,        8'b00000000, 4'h0, 32'h0,   32'h0, 32'h0));
    vq.push_back(mk(5'b00100, 4'hF, 32'h0, 32'h100, 32'h0,        8'b00000001, 4'h0, 32'h0,   32'h0, 32'h0));
    vq.push_back(mk(5'b00100, 4'hF, 32'h0, 32'h100, 32'h0,        8'b10000001, 4'hF, 32'h100, 32'h0, 32'h0));
    vq.push_back(mk(5'b00100, 4'hF, 32'h0, 32'h100, 32'h0,        8'b10000001, 4'hF, 32'h100, 32'h0, 32'h0));
    vq.push_back(mk(5'b00101, 4'hF, 32'h0, 32'h100, 32'hDEADBEEF, 8'b10000001, 4'hF, 32'h100, 32'h0, 32'h0));
    vq.push_back(mk(5'b00100, 4'hF, 32'h0, 32'h100, 32'h0,        8'b00010000, 4'hF, 32'h100, 32'h0, 32'hDEADBEEF));
    vq.push_back(mk(5'b00000, 4'hF, 32'h0, 32'h0,   32'h0,        8'b00000000, 4'hF, 32'h100, 32'h0, 32'hDEADBEEF));
    vq.push_back(mk(5'b00000, 4'hF, 32'h0, 32'h0,   32'h0,        8'b00000000, 4'hF, 32'h100, 32'h0, 32'hDEADBEEF));
    // same-cycle conflict: store first, fetch two cycles after d_ready
    vq.push_back(mk(5'b01110, 4'h3, 32'h80000000, 32'h200, 32'h0,        8'b00000011, 4'hF, 32'h100,      32'h0, 32'hDEADBEEF));
    vq.push_back(mk(5'b01111, 4'h3, 32'h80000000, 32'h200, 32'hDEADBEEF, 8'b11000011, 4'h3, 32'h200,      32'h0, 32'hDEADBEEF));
    vq.push_back(mk(5'b01110, 4'h3, 32'h80000000, 32'h200, 32'h0,        8'b01010010, 4'h3, 32'h200,      32'h0, 32'hDEADBEEF));
    vq.push_back(mk(5'b01000, 4'hF, 32'h80000000, 32'h0,   32'h0,        8'b01000010, 4'h3, 32'h200,      32'h0, 32'hDEADBEEF));
    vq.push_back(mk(5'b01000, 4'hF, 32'h80000000, 32'h0,   32'h0,        8'b10000010, 4'hF, 32'h80000000, 32'h0, 32'hDEADBEEF));
    vq.push_back(mk(5'b01001, 4'hF, 32'h80000000, 32'h0,   32'hCAFEF00D, 8'b10000010, 4'hF, 32'h80000000, 32'h0, 32'hDEADBEEF));
    vq.push_back(mk(5'b01000, 4'hF, 32'h80000000, 32'h0,   32'h0,        8'b00100000, 4'hF, 32'h80000000, 32'hCAFEF00D, 32'hDEADBEEF));
    vq.push_back(mk(5'b00000, 4'hF, 32'h0,        32'h0,   32'h0,        8'b00000000, 4'hF, 32'h80000000, 32'hCAFEF00D, 32'hDEADBEEF));
    // flush abandon: fetch dropped one cycle into the bus phase
    vq.push_back(mk(5'b01000, 4'hF, 32'h40, 32'h0, 32'h0,        8'b00000010, 4'hF, 32'h80000000, 32'hCAFEF00D, 32'hDEADBEEF));
    vq.push_back(mk(5'b01000, 4'hF, 32'h40, 32'h0, 32'h0,        8'b10000010, 4'hF, 32'h40, 32'hCAFEF00D, 32'hDEADBEEF));
    vq.push_back(mk(5'b00000, 4'hF, 32'h40, 32'h0, 32'h0,        8'b10000000, 4'hF, 32'h40, 32'hCAFEF00D, 32'hDEADBEEF));
    vq.push_back(mk(5'b00000, 4'hF, 32'h40, 32'h0, 32'h0,        8'b10000000, 4'hF, 32'h40, 32'hCAFEF00D, 32'hDEADBEEF));
    vq.push_back(mk(5'b00001, 4'hF, 32'h40, 32'h0, 32'hCAFEF00D, 8'b10000000, 4'hF, 32'h40, 32'hCAFEF00D, 32'hDEADBEEF));
    vq.push_back(mk(5'b00000, 4'hF, 32'h0,  32'h0, 32'h0,        8'b00000000, 4'hF, 32'h40, 32'hCAFEF00D, 32'hDEADBEEF));
    vq.push_back(mk(5'b00000, 4'hF, 32'h0,  32'h0, 32'h0,        8'b00000000, 4'hF, 32'h40, 32'hCAFEF00D, 32'hDEADBEEF));
    // data timeout: bus_req exactly TO cycles, then ready + error
    vq.push_back(mk(5'b00100, 4'hF, 32'h0, 32'h300, 32'h0, 8'b00000001, 4'hF, 32'h40,  32'hCAFEF00D, 32'hDEADBEEF));
    for (int i = 0; i < TO; i++)
      vq.push_back(mk(5'b00100, 4'hF, 32'h0, 32'h300, 32'h0, 8'b10000001, 4'hF, 32'h300, 32'hCAFEF00D, 32'hDEADBEEF));
    vq.push_back(mk(5'b00100, 4'hF, 32'h0, 32'h300, 32'h0, 8'b00011100, 4'hF, 32'h300, 32'hCAFEF00D, 32'h0));
    vq.push_back(mk(5'b00000, 4'hF, 32'h0, 32'h0,   32'h0, 8'b00000000, 4'hF, 32'h300, 32'hCAFEF00D, 32'h0));
    // reset in the data bus phase, late ack ignored
    vq.push_back(mk(5'b00110, 4'h5, 32'h0, 32'h400, 32'h0,        8'b00000001, 4'hF, 32'h300, 32'hCAFEF00D, 32'h0));
    vq.push_back(mk(5'b00110, 4'h5, 32'h0, 32'h400, 32'h0,        8'b11000001, 4'h5, 32'h400, 32'hCAFEF00D, 32'h0));
    vq.push_back(mk(5'b11110, 4'h5, 32'h0, 32'h400, 32'h0,        8'b11000000, 4'h5, 32'h400, 32'hCAFEF00D, 32'h0));
    vq.push_back(mk(5'b00001, 4'hF, 32'h0, 32'h0,   32'h99999999, 8'b00000000, 4'h0, 32'h0,   32'h0, 32'h0));
    vq.push_back(mk(5'b00000, 4'hF, 32'h0, 32'h0,   32'h0,        8'b00000000, 4'h0, 32'h0,   32'h0, 32'h0));

    foreach (vq[i]) begin
      @(posedge clk); #1;
      where     = i;
      reset     = vq[i].ic[4];
      if_req    = vq[i].ic[3];
      d_req     = vq[i].ic[2];
      d_we      = vq[i].ic[1];
      bus_ack   = vq[i].ic[0];
      d_be      = vq[i].dbe;
      if_addr   = vq[i].iaddr;
      d_addr    = vq[i].daddr;
      d_wdata   = 32'h55AA55AA;
      bus_rdata = vq[i].ardata;
      @(negedge clk);
      check("vec_ctl", 128'({bus_req, bus_we, if_ready, d_ready, bus_err, bus_err_src, if_stall, mem_stall}),
            128'(vq[i].ec));
      check("vec_cmd", 128'({bus_be, bus_addr}), 128'({vq[i].e_bbe, vq[i].e_baddr}));
      check("vec_rdata", 128'({if_rdata, d_rdata}), 128'({vq[i].e_irdata, vq[i].e_drdata}));
    end

    // Randomized traffic; the table ended in a freshly reset idle arbiter.
    m_active = 1'b0; m_src = 1'b0; m_aband = 1'b0; m_start = 0; m_ack_due = 0;
    m_arb_from = 0; m_we = 1'b0; m_be = 4'h0; m_addr = 32'h0; m_wdata = 32'h0;
    m_irdata = 32'h0; m_drdata = 32'h0; rep_cyc = -1; rep_src = 1'b0;
    rep_err = 1'b0; rep_aband = 1'b0;
    d_pend = 1'b0; i_pend = 1'b0;

    for (int n = 0; n < NRAND; n++) begin
      @(posedge clk); #1;
      where = 1000 + n;
      reset = ($urandom_range(0, 99) == 0);
      if (!d_pend && $urandom_range(0, 2) == 0) begin
        d_pend  = 1'b1;
        d_we    = 1'($urandom);
        d_be    = 4'($urandom);
        d_addr  = $urandom;
        d_wdata = $urandom;
      end
      d_req = d_pend;
      if (i_pend && $urandom_range(0, 15) == 0) begin
        i_pend = 1'b0;
      end else if (!i_pend && $urandom_range(0, 2) == 0) begin
        i_pend  = 1'b1;
        if_addr = $urandom;
      end
      if_req    = i_pend;
      bus_rdata = $urandom;
      if (m_active) bus_ack = (n == m_ack_due);
      else          bus_ack = ($urandom_range(0, 7) == 0);

      e_drdy = (n == rep_cyc) && rep_src;
      e_irdy = (n == rep_cyc) && !rep_src && !rep_aband;
      e_err  = (n == rep_cyc) && rep_err;

      @(negedge clk);
      check("rnd_ctl", 128'({bus_req, if_ready, d_ready, bus_err, bus_err_src}),
            128'({m_active, e_irdy, e_drdy, e_err, e_err & rep_src}));
      check("rnd_stall", 128'({if_stall, mem_stall}),
            128'({!reset && if_req && !e_irdy, !reset && d_req && !e_drdy}));
      check("rnd_rdata", 128'({if_rdata, d_rdata}), 128'({m_irdata, m_drdata}));
      if (m_active) begin
        check("rnd_cmd", 128'({bus_we, bus_be, bus_addr}), 128'({m_we, m_be, m_addr}));
        if (m_we) check("rnd_wdata", 128'(bus_wdata), 128'(m_wdata));
      end

      if (e_drdy) d_pend = 1'b0;
      if (e_irdy) i_pend = 1'b0;

      // Advance the reference model with this cycle's inputs.
      if (reset) begin
        m_active = 1'b0; m_we = 1'b0; m_be = 4'h0; m_addr = 32'h0; m_wdata = 32'h0;
        m_irdata = 32'h0; m_drdata = 32'h0; rep_cyc = -1; m_arb_from = n + 1;
      end else if (m_active) begin
        if (!m_src && !if_req) m_aband = 1'b1;
        if (bus_ack || (n - m_start) == TO) begin
          dat = bus_ack ? bus_rdata : 32'h0;
          if (m_src) m_drdata = dat;
          else       m_irdata = dat;
          rep_cyc    = n + 1;
          rep_src    = m_src;
          rep_err    = !bus_ack;
          rep_aband  = m_aband;
          m_active   = 1'b0;
          m_arb_from = n + 2;
        end
      end else if (n >= m_arb_from && (d_req || if_req)) begin
        m_active  = 1'b1;
        m_start   = n;
        m_aband   = 1'b0;
        m_src     = d_req;
        m_ack_due = n + 1 + int'($urandom_range(0, 5));
        if (d_req) begin
          m_we = d_we; m_be = d_be; m_addr = d_addr; m_wdata = d_wdata;
        end else begin
          m_we = 1'b0; m_be = 4'hF; m_addr = if_addr;
        end
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Shares the single external memory bus between the instruction-fetch port (IF stage) and the data port (MEM stage) of the pipeline CPU. It runs a five-state handshake FSM with fixed data-over-instruction priority and a bus-timeout watchdog. It drives `if_stall` and `mem_stall`; `mem_stall` feeds the hazard control unit, which freezes every pipeline register while it is high. A timeout reports a one-cycle `bus_err` pulse for exception handling.

## Interface
- `TIMEOUT`, default 255: number of bus-wait cycles without `bus_ack` before the access is aborted (1..255).
- `clk` in 1: clock, rising edge.
- `reset` in 1: reset, synchronous, active-high.
- `if_req` in 1: fetch request. Held until `if_ready`; may drop early on a flush.
- `if_addr` in 32: fetch address.
- `if_ready` out 1: one-cycle pulse; fetch data valid.
- `if_rdata` out 32: fetched word, registered.
- `d_req` in 1: data request. Must stay high until `d_ready`.
- `d_we` in 1, `d_be` in 4, `d_addr` in 32, `d_wdata` in 32: write enable, byte enables, address, write data.
- `d_ready` out 1: one-cycle pulse; access complete.
- `d_rdata` out 32: load data, registered.
- `bus_req` out 1, `bus_we` out 1, `bus_be` out 4, `bus_addr` out 32, `bus_wdata` out 32: registered bus command.
- `bus_ack` in 1: slave completion, one cycle.
- `bus_rdata` in 32: valid in the `bus_ack` cycle.
- `if_stall` out 1: `if_req & ~if_ready`.
- `mem_stall` out 1: `d_req & ~d_ready`.
- `bus_err` out 1: one-cycle timeout pulse.
- `bus_err_src` out 1: source of the timed-out access. 0 = fetch, 1 = data.

## Operation
- States: `IDLE`, `DBUS`, `IBUS`, `DDONE`, `IDONE`.
- `IDLE`:
  - If `d_req`: latch the data command onto the `bus_*` registers, set `bus_req`, go to `DBUS`.
  - Else if `if_req`: latch `if_addr` with `bus_we=0` and `bus_be=4'hF`, set `bus_req`, go to `IBUS`.
  - Data always wins a same-cycle conflict. Starvation is impossible because a pending data access already freezes the IF stage.
- `DBUS`/`IBUS`:
  - Hold the `bus_*` outputs stable.
  - On `bus_ack`: clear `bus_req`, capture `bus_rdata` into `d_rdata` (in `DBUS`) or `if_rdata` (in `IBUS`), go to `DDONE`/`IDONE`.
- Timeout:
  - 8-bit `wait_cnt` clears on entry to `DBUS`/`IBUS` and increments each cycle there without `bus_ack`.
  - When `wait_cnt == TIMEOUT-1` and there is no ack: clear `bus_req`, load the rdata register with 0, pulse `bus_err` in the DONE cycle with `bus_err_src` set, go to DONE.
- `DDONE`: `d_ready=1`, then go to `IDLE`.
- `IDONE`: `if_ready = ~abandon`, then go to `IDLE`.
- No new grant starts in a DONE state. The still-high old `req` must not be re-serviced.
- Abandon flag:
  - Set if `if_req` is low in any `IBUS` cycle.
  - The bus transaction still completes, since the bus cannot be aborted; the result is discarded and `if_ready` stays low.
  - Cleared on `IDLE` entry.
- `d_req` dropping mid-access is illegal; the behaviour is unspecified.
- A `bus_ack` arriving in `IDLE`/DONE is ignored.
- `rdata` registers hold their value until the next capture.

## Timing
- Reset (synchronous):
  - State goes to `IDLE`.
  - `bus_req`, `bus_we`, `if_ready`, `d_ready`, `bus_err`, `bus_err_src` go to 0.
  - `bus_be`, `bus_addr`, `bus_wdata`, `if_rdata`, `d_rdata`, `wait_cnt` go to 0.
  - `if_stall` and `mem_stall` are forced to 0 while `reset` is high.
  - Reset mid-transaction drops `bus_req` at the next edge; any later ack is ignored.
- Latency, with `req` sampled at cycle t:
  - `bus_req` is high from t+1.
  - An ack at t+k (k≥1) gives ready at t+k+1.
  - Arbitration resumes at t+k+2, so the minimum access is 3 cycles.
- Timeout: `bus_req` is high for exactly `TIMEOUT` cycles; `ready`/`bus_err` are at t+TIMEOUT+1.
- Stalls are combinational. `mem_stall` falls in the `d_ready` cycle, so the pipeline advances on that edge.

## Test plan
- **Single load.** `d_req`, `d_we=0`, `d_addr=0x100`; slave acks 2 cycles after `bus_req` with `0xDEADBEEF`.
  - `d_ready` at t+4 with `d_rdata=0xDEADBEEF`.
  - `mem_stall` high for t..t+3.
- **Same-cycle conflict.** `d_req` (store `0x55AA55AA` to `0x200`, `be=4'b0011`) and `if_req` (`0x80000000`) together, 1-cycle ack.
  - Data goes first with `bus_be=0011`.
  - Fetch `bus_req` rises 2 cycles after `d_ready`.
- **Flush abandon.** `if_req` for `0x40`, dropped one cycle into `IBUS`, ack after 3 cycles.
  - The bus transaction completes.
  - `if_ready` never pulses; `IDLE` is reached.
- **Timeout.** `TIMEOUT=4`, data request, no ack.
  - `bus_req` is high exactly 4 cycles.
  - Then `d_ready=1`, `d_rdata=0`, `bus_err=1`, `bus_err_src=1` for one cycle.
- **Reset mid-access.** Reset asserted in `DBUS`.
  - All outputs read 0 next cycle.
  - A late `bus_ack` produces no `ready`.
- **Held request.** `d_req` held high through the `DDONE` cycle.
  - No second bus access starts in the DDONE cycle or the following one.
